// File: rtl/regfile_ctrl_pkg.sv
// Shared types and defaults for the register-file port controller.
// Imported by the controller top and its starvation guard.
package regfile_ctrl_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int NUM_REGS_D = 32;
  localparam int ADDR_W_D   = 5;
  localparam int DATA_W_D   = 32;
  localparam int REG_ZERO   = 0;

endpackage

// File: rtl/regfile_starve_guard.sv
// Saturating refusal counter for the debug requester.
// Raises a registered stall request once the limit is reached.
module regfile_starve_guard #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic count_en,
  input  logic clear,
  output logic stall_req
);

  localparam logic [7:0] LIM = 8'(STARVE_LIMIT);

  logic [7:0] cnt;
  logic [7:0] cnt_inc;

  assign cnt_inc = cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      stall_req <= 1'b0;
    end else if (clear) begin
      cnt       <= '0;
      stall_req <= 1'b0;
    end else if (count_en && cnt != LIM) begin
      cnt       <= cnt_inc;
      stall_req <= (cnt_inc == LIM);
    end
  end

endmodule

// File: rtl/regfile_port_ctrl.sv
// Owns the register-file write port and read port 2: zero-fill after
// reset, then writeback-first arbitration with a debug requester.
module regfile_port_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int NUM_REGS     = NUM_REGS_D,
  parameter int ADDR_W       = ADDR_W_D,
  parameter int DATA_W       = DATA_W_D,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_rd_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic [ADDR_W-1:0] pipe_rs2_i,
  input  logic              pipe_rs2_used_i,
  input  logic              dbg_valid_i,
  input  logic              dbg_write_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_ready_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic [ADDR_W-1:0] rf_raddr2_o,
  input  logic [DATA_W-1:0] rf_rdata2_i,
  output logic              busy_o,
  output logic              stall_req_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] init_cnt, init_nxt;

  logic is_run;
  logic wb_sel;
  logic xfer;
  logic rd_xfer;
  logic wr_xfer;

  assign is_run  = (state == RUN);
  assign busy_o  = !is_run;
  assign wb_sel  = is_run && wb_we_i;

  assign dbg_ready_o = is_run &&
                       (dbg_write_i ? !wb_we_i : !pipe_rs2_used_i);
  assign xfer    = dbg_valid_i && dbg_ready_o;
  assign rd_xfer = xfer && !dbg_write_i;
  assign wr_xfer = xfer && dbg_write_i;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    init_nxt  = '0;
    if (state == INIT) begin
      init_nxt = init_cnt + 1'b1;
      if (init_cnt == LAST) begin
        state_nxt = RUN;
        init_nxt  = '0;
      end
    end
  end

  always_comb begin
    rf_we_o     = 1'b0;
    rf_waddr_o  = init_cnt;
    rf_wdata_o  = '0;
    rf_raddr2_o = rd_xfer ? dbg_addr_i : pipe_rs2_i;
    unique case (1'b1)
      !is_run: begin
        rf_we_o = 1'b1;
      end
      wb_sel: begin
        rf_we_o    = (wb_rd_i != ZERO);
        rf_waddr_o = wb_rd_i;
        rf_wdata_o = wb_data_i;
      end
      wr_xfer: begin
        rf_we_o    = (dbg_addr_i != ZERO);
        rf_waddr_o = dbg_addr_i;
        rf_wdata_o = dbg_wdata_i;
      end
      default: ;
    endcase
  end

  // Read data is captured before any same-edge write lands.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      dbg_rvalid_o <= 1'b0;
      dbg_rdata_o  <= '0;
    end else begin
      dbg_rvalid_o <= rd_xfer;
      if (rd_xfer) dbg_rdata_o <= rf_rdata2_i;
    end
  end

  regfile_starve_guard #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_guard (
    .clk       (clk_i),
    .rst_n     (reset_i),
    .count_en  (is_run && dbg_valid_i && !dbg_ready_o),
    .clear     (!is_run || !dbg_valid_i || xfer),
    .stall_req (stall_req_o)
  );

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Scoreboard bench for regfile_port_ctrl with a behavioural
// register model and a separate physical register file.
module tb_regfile_port_ctrl;

  localparam int NR  = 32;
  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int LIM = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wb_we_i = 1'b0;
  logic [AW-1:0] wb_rd_i = '0;
  logic [DW-1:0] wb_data_i = '0;
  logic [AW-1:0] pipe_rs2_i = '0;
  logic          pipe_rs2_used_i = 1'b0;
  logic          dbg_valid_i = 1'b0;
  logic          dbg_write_i = 1'b0;
  logic [AW-1:0] dbg_addr_i = '0;
  logic [DW-1:0] dbg_wdata_i = '0;
  logic          dbg_ready_o;
  logic          dbg_rvalid_o;
  logic [DW-1:0] dbg_rdata_o;
  logic          rf_we_o;
  logic [AW-1:0] rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;
  logic [AW-1:0] rf_raddr2_o;
  logic [DW-1:0] rf_rdata2_i;
  logic          busy_o;
  logic          stall_req_o;

  always #5 clk = ~clk;

  regfile_port_ctrl #(
    .NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)
  ) dut (
    .clk_i           (clk),
    .reset_i         (rst_n),
    .wb_we_i         (wb_we_i),
    .wb_rd_i         (wb_rd_i),
    .wb_data_i       (wb_data_i),
    .pipe_rs2_i      (pipe_rs2_i),
    .pipe_rs2_used_i (pipe_rs2_used_i),
    .dbg_valid_i     (dbg_valid_i),
    .dbg_write_i     (dbg_write_i),
    .dbg_addr_i      (dbg_addr_i),
    .dbg_wdata_i     (dbg_wdata_i),
    .dbg_ready_o     (dbg_ready_o),
    .dbg_rvalid_o    (dbg_rvalid_o),
    .dbg_rdata_o     (dbg_rdata_o),
    .rf_we_o         (rf_we_o),
    .rf_waddr_o      (rf_waddr_o),
    .rf_wdata_o      (rf_wdata_o),
    .rf_raddr2_o     (rf_raddr2_o),
    .rf_rdata2_i     (rf_rdata2_i),
    .busy_o          (busy_o),
    .stall_req_o     (stall_req_o)
  );

  // Physical register file: no reset, starts with garbage.
  logic [DW-1:0] mem [NR];
  initial for (int i = 0; i < NR; i++) mem[i] <= $urandom;
  always @(posedge clk) if (rf_we_o) mem[rf_waddr_o] <= rf_wdata_o;
  assign rf_rdata2_i = mem[rf_raddr2_o];

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] model [NR];
  logic [DW-1:0] sbq [$];
  int cyc = 0;
  int refused = 0;
  bit exp_stall = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (dbg_rvalid_o) begin
      if (sbq.size() == 0) chk("rvalid_spurious", 32'(dbg_rvalid_o), 32'd0);
      else chk("dbg_rdata", dbg_rdata_o, sbq.pop_front());
    end
  end

  task automatic drive(input bit we, input bit [4:0] rd,
                       input bit [31:0] wd, input bit [4:0] rs2,
                       input bit used, input bit dv, input bit dw,
                       input bit [4:0] da, input bit [31:0] dwd);
    wb_we_i = we; wb_rd_i = rd; wb_data_i = wd;
    pipe_rs2_i = rs2; pipe_rs2_used_i = used;
    dbg_valid_i = dv; dbg_write_i = dw;
    dbg_addr_i = da; dbg_wdata_i = dwd;
  endtask

  // One clock: drive at negedge, check, model update at posedge.
  task automatic cycle(input bit we, input bit [4:0] rd,
                       input bit [31:0] wd, input bit [4:0] rs2,
                       input bit used, input bit dv, input bit dw,
                       input bit [4:0] da, input bit [31:0] dwd,
                       output bit acc);
    bit run, rdy, xfer, ewe;
    xfer = 1'b0;
    if (exp_stall) begin we = 1'b0; used = 1'b0; end
    drive(we, rd, wd, rs2, used, dv, dw, da, dwd);
    #1;
    run = (cyc >= NR);
    if (!run) begin
      chk("init_busy", 32'(busy_o), 32'd1);
      chk("init_we", 32'(rf_we_o), 32'd1);
      chk("init_waddr", 32'(rf_waddr_o), 32'(cyc));
      chk("init_wdata", rf_wdata_o, 32'd0);
      chk("init_ready", 32'(dbg_ready_o), 32'd0);
    end else begin
      rdy  = dw ? !we : !used;
      xfer = dv && rdy;
      ewe  = we ? (rd != 0) : (xfer && dw && da != 0);
      chk("busy", 32'(busy_o), 32'd0);
      chk("dbg_ready", 32'(dbg_ready_o), 32'(rdy));
      chk("rf_we", 32'(rf_we_o), 32'(ewe));
      if (ewe) begin
        chk("rf_waddr", 32'(rf_waddr_o), 32'(we ? rd : da));
        chk("rf_wdata", rf_wdata_o, we ? wd : dwd);
      end
      chk("rf_raddr2", 32'(rf_raddr2_o), 32'((xfer && !dw) ? da : rs2));
      chk("stall_req", 32'(stall_req_o), 32'(exp_stall));
    end
    acc = run && xfer;
    @(posedge clk);
    if (run) begin
      if (xfer && !dw) sbq.push_back(model[da]);
      if (we && rd != 0) model[rd] = wd;
      else if (xfer && dw && da != 0) model[da] = dwd;
      if (dv && !xfer) refused = (refused < LIM) ? refused + 1 : LIM;
      else refused = 0;
      exp_stall = (refused == LIM);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sbq.delete();
    for (int i = 0; i < NR; i++) model[i] = '0;
    cyc = 0; refused = 0; exp_stall = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_busy", 32'(busy_o), 32'd1);
    chk("rst_stall", 32'(stall_req_o), 32'd0);
    chk("rst_rvalid", 32'(dbg_rvalid_o), 32'd0);
    chk("rst_rdata", dbg_rdata_o, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, a);
  endtask

  task automatic rd(input bit [4:0] addr);
    bit a;
    cycle(0, 0, 0, 0, 0, 1, 0, addr, 0, a);
  endtask

  task automatic wr_until(input bit [4:0] addr, input bit [31:0] d);
    bit a;
    a = 1'b0;
    for (int i = 0; i < 4 && !a; i++)
      cycle(0, 0, 0, 0, 0, 1, 1, addr, d, a);
  endtask

  bit acc;
  bit req_v, req_w;
  bit [4:0] req_a;
  bit [31:0] req_d;

  initial begin
    #2;
    do_reset();
    idle(NR);
    for (int i = 0; i < NR; i++) rd(5'(i));

    cycle(1, 5, 32'hDEADBEEF, 0, 0, 1, 1, 7, 32'hCAFEF00D, acc);
    wr_until(7, 32'hCAFEF00D);
    rd(5); rd(0); rd(7);

    cycle(1, 0, 32'h1234, 0, 0, 1, 1, 0, 32'h5555, acc);
    wr_until(0, 32'h5555);
    rd(0);

    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++)
      cycle(0, 0, 0, 9, 1, 1, 0, 5, 0, acc);
    idle(2);

    drive(0, 0, 0, 0, 0, 1, 0, 5, 0);
    @(posedge clk);
    #1;
    do_reset();
    idle(NR);
    rd(5); rd(7);

    req_v = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (!req_v && ($urandom % 3 == 0)) begin
        req_v = 1'b1;
        req_w = 1'($urandom);
        req_a = 5'($urandom);
        req_d = $urandom;
      end
      cycle(1'($urandom), 5'($urandom), $urandom, 5'($urandom),
            1'($urandom), req_v, req_w, req_a, req_d, acc);
      if (acc) req_v = 1'b0;
    end
    idle(3);
    chk("sb_drain", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
